// File: rtl/reg_delay_pipe.sv
// Stallable, flushable delay line for destination register indices with a
// per-stage valid bit, plus a same-cycle hazard lookup that reports the
// youngest valid stage holding a given source index.
module reg_delay_pipe #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter bit          SKIP_ZERO   = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    stall,
    input  logic                                    flush,
    input  logic                                    in_valid,
    input  logic [WIDTH-1:0]                        in_data,
    output logic                                    out_valid,
    output logic [WIDTH-1:0]                        out_data,
    output logic [DEPTH-1:0]                        stage_valid,
    output logic [$clog2(DEPTH+1)-1:0]              occupancy,
    input  logic [WIDTH-1:0]                        rs1,
    input  logic [WIDTH-1:0]                        rs2,
    output logic                                    hit1,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] hit1_stage,
    output logic                                    hit2,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] hit2_stage
);

    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned STG_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          DEPTH_I = int'(DEPTH);

    // Bit i set when stage i is cleared by flush; the youngest FLUSH_DEPTH stages.
    localparam logic [DEPTH-1:0] FLUSH_MASK = DEPTH'((65'(1) << FLUSH_DEPTH) - 65'(1));

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [OCC_W-1:0]            occ_q;
    logic                        admit;

    // Number of set bits in a valid vector.
    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH_I; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Youngest valid stage whose data equals rs; returns {hit, stage}.
    function automatic logic [STG_W:0] lookup(
        input logic [DEPTH-1:0][WIDTH-1:0] d,
        input logic [DEPTH-1:0]            v,
        input logic [WIDTH-1:0]            rs
    );
        logic             hit;
        logic [STG_W-1:0] stg;
        hit = 1'b0;
        stg = '0;
        // Scan oldest to youngest so the youngest match is the one kept.
        for (int i = DEPTH_I - 1; i >= 0; i--) begin
            if (v[i] && (d[i] == rs)) begin
                hit = 1'b1;
                stg = STG_W'(i);
            end
        end
        // x0 is never a real dependency when zero entries are suppressed.
        if (SKIP_ZERO && (rs == '0)) begin
            hit = 1'b0;
            stg = '0;
        end
        return {hit, stg};
    endfunction

    // An input counts as a live entry unless it targets x0 with suppression on.
    always_comb begin
        admit = in_valid && !(SKIP_ZERO && (in_data == '0));
    end

    // Next stage contents: shift or hold, then flush clears the young stages.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (!stall) begin
            data_d[0]  = in_data;
            valid_d[0] = admit;
            for (int i = 1; i < DEPTH_I; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i < DEPTH_I; i++) begin
                if (FLUSH_MASK[i]) begin
                    data_d[i]  = '0;
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    // Stage registers and registered occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= popcount(valid_d);
        end
    end

    // Registered outputs taken straight from the stage flops.
    always_comb begin
        out_valid   = valid_q[DEPTH-1];
        out_data    = data_q[DEPTH-1];
        stage_valid = valid_q;
        occupancy   = occ_q;
    end

    // Same-cycle hazard lookup for both source operands.
    always_comb begin
        {hit1, hit1_stage} = lookup(data_q, valid_q, rs1);
        {hit2, hit2_stage} = lookup(data_q, valid_q, rs2);
    end

endmodule
